// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect/halt control
// from later stages, and the decode-facing handshake.
interface fetch_stage_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);
   logic [ADDRESS_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0]    imem_data;
   logic                     redirect_valid;
   logic [ADDRESS_WIDTH-1:0] redirect_pc;
   logic                     halt_req;
   logic                     id_ready;
   logic                     id_valid;
   logic [DATA_WIDTH-1:0]    id_instr;
   logic [ADDRESS_WIDTH-1:0] id_pc;
   logic [ADDRESS_WIDTH-1:0] id_pc_plus4;
   logic                     fetch_err;

   // Fetch-stage side.
   modport master (
      output imem_addr,
      input  imem_data,
      input  redirect_valid,
      input  redirect_pc,
      input  halt_req,
      input  id_ready,
      output id_valid,
      output id_instr,
      output id_pc,
      output id_pc_plus4,
      output fetch_err
   );

   // Memory / decode / control side.
   modport slave (
      input  imem_addr,
      output imem_data,
      output redirect_valid,
      output redirect_pc,
      output halt_req,
      output id_ready,
      input  id_valid,
      input  id_instr,
      input  id_pc,
      input  id_pc_plus4,
      input  fetch_err
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, small {instr, pc, pc+4} FIFO toward
// decode, RUN/HALT control with redirect flush and sticky misalignment flag.
module fetch_stage #(
   parameter int                     ADDRESS_WIDTH = 32,
   parameter int                     DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0,
   parameter int                     DEPTH         = 2
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);
   // Pointers and count sized for the legal DEPTH range 2..4.
   localparam int CNT_W = 3;
   localparam int PTR_W = 2;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic                     err_q, err_d;
   logic                     push, pop, aligned;

   logic [DATA_WIDTH-1:0]    instr_q [DEPTH];
   logic [ADDRESS_WIDTH-1:0] pc_ent_q [DEPTH];
   logic [ADDRESS_WIDTH-1:0] pc4_ent_q [DEPTH];

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign aligned = (bus.redirect_pc[1:0] == 2'b00);

   // Next-state, push/pop decisions, PC and error flag; redirect dominates.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      err_d    = err_q;
      pop      = 1'b0;
      push     = 1'b0;
      if (bus.redirect_valid) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         if (aligned) begin
            pc_d    = bus.redirect_pc;
            state_d = RUN;
         end else begin
            err_d   = 1'b1;
            state_d = HALT;
         end
      end else begin
         pop  = (count_q != '0) && bus.id_ready;
         push = (state_q == RUN) && !bus.halt_req && ((count_q < DEPTH_C) || pop);
         if (state_q == RUN && bus.halt_req) begin
            state_d = HALT;
         end
         if (push) begin
            pc_d     = pc_q + ADDRESS_WIDTH'(4);
            wr_ptr_d = next_ptr(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         err_q    <= err_d;
      end
   end

   // FIFO storage; cleared on reset so the head reads zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i]   <= '0;
            pc_ent_q[i]  <= '0;
            pc4_ent_q[i] <= '0;
         end
      end else if (push) begin
         instr_q[wr_ptr_q]   <= bus.imem_data;
         pc_ent_q[wr_ptr_q]  <= pc_q;
         pc4_ent_q[wr_ptr_q] <= pc_q + ADDRESS_WIDTH'(4);
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.id_valid    = (count_q != '0);
   assign bus.id_instr    = instr_q[rd_ptr_q];
   assign bus.id_pc       = pc_ent_q[rd_ptr_q];
   assign bus.id_pc_plus4 = pc4_ent_q[rd_ptr_q];
   assign bus.fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main instance (RESET_PC 0, DEPTH 2) plus a
// second instance with RESET_PC 0xFFFF_FFFC to exercise PC wrap.
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fetch_stage_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) a_if ();
   fetch_stage_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) b_if ();

   fetch_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .DEPTH(2))
      dut_a (.clk(clk), .rst(rst), .bus(a_if.master));

   fetch_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2))
      dut_b (.clk(clk), .rst(rst), .bus(b_if.master));

   // Word at byte address a: 0x13, 0x00100093, 0x00200113, ...
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0000_0013 + (a >> 2) * 32'h0010_0080;
   endfunction

   assign a_if.imem_data = mem_word(a_if.imem_addr);
   assign b_if.imem_data = mem_word(b_if.imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_if.redirect_valid = 1'b0;
      a_if.redirect_pc    = '0;
      a_if.halt_req       = 1'b0;
      a_if.id_ready       = 1'b1;
      b_if.redirect_valid = 1'b0;
      b_if.redirect_pc    = '0;
      b_if.halt_req       = 1'b0;
      b_if.id_ready       = 1'b1;

      // Reset state
      rst = 1'b1;
      step();
      check("rst_valid", 32'(a_if.id_valid), 32'd0);
      check("rst_addr", a_if.imem_addr, 32'h0);
      check("rst_pc", a_if.id_pc, 32'h0);
      check("rst_instr", a_if.id_instr, 32'h0);
      check("rst_pc4", a_if.id_pc_plus4, 32'h0);
      check("rst_err", 32'(a_if.fetch_err), 32'd0);
      check("b_rst_addr", b_if.imem_addr, 32'hFFFF_FFFC);

      // Streaming with id_ready = 1
      rst = 1'b0;
      step();
      check("s1_valid", 32'(a_if.id_valid), 32'd1);
      check("s1_pc", a_if.id_pc, 32'h0);
      check("s1_instr", a_if.id_instr, 32'h0000_0013);
      check("s1_addr", a_if.imem_addr, 32'h4);
      check("b_wrap_addr", b_if.imem_addr, 32'h0);
      check("b_wrap_pc", b_if.id_pc, 32'hFFFF_FFFC);
      check("b_wrap_pc4", b_if.id_pc_plus4, 32'h0);
      step();
      check("s2_pc", a_if.id_pc, 32'h4);
      check("s2_instr", a_if.id_instr, 32'h0010_0093);
      check("b_s2_pc", b_if.id_pc, 32'h0);
      step();
      check("s3_pc", a_if.id_pc, 32'h8);
      check("s3_addr", a_if.imem_addr, 32'hC);

      // Backpressure: restart from reset with id_ready low for 5 cycles
      rst = 1'b1;
      step();
      rst = 1'b0;
      a_if.id_ready = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("bp_addr", a_if.imem_addr, 32'h8);
      check("bp_valid", 32'(a_if.id_valid), 32'd1);
      check("bp_head", a_if.id_pc, 32'h0);
      a_if.id_ready = 1'b1;
      step();
      check("bp_drain1", a_if.id_pc, 32'h4);
      check("bp_addr2", a_if.imem_addr, 32'hC);
      step();
      check("bp_drain2", a_if.id_pc, 32'h8);

      // Aligned redirect while full
      a_if.redirect_valid = 1'b1;
      a_if.redirect_pc    = 32'h40;
      step();
      a_if.redirect_valid = 1'b0;
      check("rd_valid", 32'(a_if.id_valid), 32'd0);
      check("rd_addr", a_if.imem_addr, 32'h40);
      step();
      check("rd_pc", a_if.id_pc, 32'h40);
      check("rd_instr", a_if.id_instr, 32'h0100_0813);
      check("rd_pc4", a_if.id_pc_plus4, 32'h44);

      // Misaligned redirect, then aligned resume
      a_if.redirect_valid = 1'b1;
      a_if.redirect_pc    = 32'h42;
      step();
      a_if.redirect_valid = 1'b0;
      check("mis_err", 32'(a_if.fetch_err), 32'd1);
      check("mis_valid", 32'(a_if.id_valid), 32'd0);
      check("mis_addr", a_if.imem_addr, 32'h44);
      step();
      check("halt_valid", 32'(a_if.id_valid), 32'd0);
      check("halt_addr", a_if.imem_addr, 32'h44);
      a_if.redirect_valid = 1'b1;
      a_if.redirect_pc    = 32'h80;
      step();
      a_if.redirect_valid = 1'b0;
      check("res_addr", a_if.imem_addr, 32'h80);
      check("res_valid", 32'(a_if.id_valid), 32'd0);
      step();
      check("res_pc", a_if.id_pc, 32'h80);
      check("res_err", 32'(a_if.fetch_err), 32'd1);

      // halt_req at count 1: entry pops, no more pushes
      a_if.halt_req = 1'b1;
      step();
      a_if.halt_req = 1'b0;
      check("hq_valid", 32'(a_if.id_valid), 32'd0);
      check("hq_addr", a_if.imem_addr, 32'h84);
      step();
      check("hq_valid2", 32'(a_if.id_valid), 32'd0);
      check("hq_addr2", a_if.imem_addr, 32'h84);

      // Fill to full, then reset together with a redirect
      a_if.redirect_valid = 1'b1;
      a_if.redirect_pc    = 32'h100;
      step();
      a_if.redirect_valid = 1'b0;
      a_if.id_ready       = 1'b0;
      step();
      step();
      check("full_addr", a_if.imem_addr, 32'h108);
      rst = 1'b1;
      a_if.redirect_valid = 1'b1;
      a_if.redirect_pc    = 32'h200;
      step();
      check("mrst_valid", 32'(a_if.id_valid), 32'd0);
      check("mrst_addr", a_if.imem_addr, 32'h0);
      check("mrst_err", 32'(a_if.fetch_err), 32'd0);
      check("mrst_pc", a_if.id_pc, 32'h0);
      check("mrst_instr", a_if.id_instr, 32'h0);
      check("mrst_pc4", a_if.id_pc_plus4, 32'h0);
      rst = 1'b0;
      a_if.redirect_valid = 1'b0;
      a_if.id_ready       = 1'b1;
      step();
      check("post_pc", a_if.id_pc, 32'h0);
      check("post_valid", 32'(a_if.id_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
